// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and byte-enable legality.
package dmem_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  typedef enum logic [1:0] {
    StIdle = IDLE,
    StWait = WAIT,
    StResp = RESP
  } dmem_state_e;

  localparam logic [3:0] BeByte0 = 4'b0001;
  localparam logic [3:0] BeByte1 = 4'b0010;
  localparam logic [3:0] BeByte2 = 4'b0100;
  localparam logic [3:0] BeByte3 = 4'b1000;
  localparam logic [3:0] BeHalf0 = 4'b0011;
  localparam logic [3:0] BeHalf1 = 4'b1100;
  localparam logic [3:0] BeWord  = 4'b1111;

  // Only naturally aligned byte, half and word lane patterns are valid for stores.
  function automatic logic be_legal(input logic [3:0] be);
    logic ok;
    case (be)
      BeByte0, BeByte1, BeByte2, BeByte3, BeHalf0, BeHalf1, BeWord: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// LSU <-> data-memory request/response channels; master is the LSU, slave the memory.
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_be, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-wide synchronous single-port RAM with per-byte write enables; contents are never reset.
module dmem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) begin
            mem[addr][8*i +: 8] <= wdata[8*i +: 8];
          end
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side slave for CPU loads/stores: one request at a time, programmable wait,
// fault on out-of-range, misaligned or illegal-lane accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input logic              clk,
  input logic              rst,
  dmem_responder_if.slave  bus
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam bit          NoWait  = (WAIT_CYCLES == 0);
  localparam logic [3:0]  CntInit = 4'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  dmem_state_e   state_q;
  logic [3:0]    cnt_q;
  logic          ready_q;
  logic          rsp_valid_q;
  logic          rsp_err_q;
  logic          rd_sel_q;

  logic          we_q;
  logic [AW-1:0] idx_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          fault_q;

  logic [31:0]   req_off;
  logic          req_fault;
  logic          accept;

  logic          acc_fire;
  logic          acc_we;
  logic [AW-1:0] acc_idx;
  logic [3:0]    acc_be;
  logic [31:0]   acc_wdata;
  logic          acc_fault;
  logic [31:0]   ram_rdata;

  // Offset wraps, so addresses below BASE_ADDR land far above the array and fault.
  assign req_off   = bus.req_addr - BASE_ADDR;
  assign req_fault = (|req_off[31:AW+2]) || (req_off[1:0] != 2'b00) ||
                     (bus.req_we && !be_legal(bus.req_be));

  assign bus.req_ready = ready_q && !rst;
  assign accept        = bus.req_valid && bus.req_ready;

  // The RAM operation happens on the edge that enters RESP: from IDLE when there is no
  // wait, otherwise from the last WAIT cycle using the latched request.
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = we_q;
    acc_idx   = idx_q;
    acc_be    = be_q;
    acc_wdata = wdata_q;
    acc_fault = fault_q;
    if (NoWait && state_q == StIdle && accept) begin
      acc_fire  = 1'b1;
      acc_we    = bus.req_we;
      acc_idx   = req_off[AW+1:2];
      acc_be    = bus.req_be;
      acc_wdata = bus.req_wdata;
      acc_fault = req_fault;
    end else if (state_q == StWait && cnt_q == '0) begin
      acc_fire = 1'b1;
    end
    if (rst) begin
      acc_fire = 1'b0;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (acc_fire && !acc_fault),
    .we    (acc_we),
    .be    (acc_be),
    .addr  (acc_idx),
    .wdata (acc_wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      ready_q     <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rd_sel_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            we_q    <= bus.req_we;
            idx_q   <= req_off[AW+1:2];
            be_q    <= bus.req_be;
            wdata_q <= bus.req_wdata;
            fault_q <= req_fault;
            ready_q <= 1'b0;
            if (NoWait) begin
              state_q     <= StResp;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= req_fault;
              rd_sel_q    <= !bus.req_we && !req_fault;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntInit;
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q     <= StResp;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= fault_q;
            rd_sel_q    <= !we_q && !fault_q;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rd_sel_q    <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // RAM output register holds its value through RESP; gating zeroes stores and faults.
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rd_sel_q ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut1 uses WAIT_CYCLES=1, dut0 uses WAIT_CYCLES=0 for back-to-back timing.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc1_n = 0;
  int   acc0_q[$];
  int   rsp0_c[$];
  logic [31:0] rsp0_d[$];
  logic        rsp0_e[$];

  always #5 clk = ~clk;

  dmem_responder_if b1 ();
  dmem_responder_if b0 ();

  dmem_responder #(
    .DEPTH       (1024),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  dmem_responder #(
    .DEPTH       (1024),
    .BASE_ADDR   (32'h0000_0000),
    .WAIT_CYCLES (0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (b1.req_valid && b1.req_ready) acc1_n <= acc1_n + 1;
    if (b0.req_valid && b0.req_ready) acc0_q.push_back(cyc);
    if (b0.rsp_valid && b0.rsp_ready) begin
      rsp0_c.push_back(cyc);
      rsp0_d.push_back(b0.rsp_rdata);
      rsp0_e.push_back(b0.rsp_err);
    end
  end

  // One transaction on dut1 with rsp_ready held high; lat counts cycles from accept to rsp_valid.
  task automatic txn1(input logic we, input logic [31:0] addr, input logic [3:0] be,
                      input logic [31:0] wdata, output logic [31:0] rdata, output logic err,
                      output int lat);
    int n;
    @(negedge clk);
    b1.req_valid = 1'b1;
    b1.req_we    = we;
    b1.req_addr  = addr;
    b1.req_be    = be;
    b1.req_wdata = wdata;
    b1.rsp_ready = 1'b1;
    n = 0;
    while (!b1.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    b1.req_valid = 1'b0;
    lat = 1;
    while (!b1.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rdata = b1.rsp_rdata;
    err   = b1.rsp_err;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = '0; b1.req_be = '0;
    b1.req_wdata = '0;   b1.rsp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_we = 1'b0; b0.req_addr = '0; b0.req_be = '0;
    b0.req_wdata = '0;   b0.rsp_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (b1.req_ready !== 1'b0) begin
      errors++; $display("FAIL reset_req_ready_low got %b want 0", b1.req_ready);
    end
    checks++;
    if (b1.rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_valid got %b want 0", b1.rsp_valid);
    end
    checks++;
    if (b1.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rsp_rdata got %h want 0", b1.rsp_rdata);
    end
    checks++;
    if (b1.rsp_err !== 1'b0) begin
      errors++; $display("FAIL reset_rsp_err got %b want 0", b1.rsp_err);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (b1.req_ready !== 1'b1 || b0.req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready got %b/%b want 1/1", b1.req_ready, b0.req_ready);
    end
  endtask

  task automatic test_store_load();
    logic [31:0] rd; logic er; int lat;
    txn1(1'b1, 32'h10, 4'b1111, 32'hDEADBEEF, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      errors++; $display("FAIL store_word got err=%b rdata=%h lat=%0d want 0/0/2", er, rd, lat);
    end
    txn1(1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEADBEEF || lat != 2) begin
      errors++; $display("FAIL load_word got err=%b rdata=%h lat=%0d want 0/deadbeef/2", er, rd, lat);
    end
  endtask

  task automatic test_byte_enable();
    logic [31:0] rd; logic er; int lat;
    txn1(1'b1, 32'h10, 4'b0010, 32'h0000_AA00, rd, er, lat);
    txn1(1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'hDEADAAEF) begin
      errors++; $display("FAIL byte1_store got err=%b rdata=%h want 0/deadaaef", er, rd);
    end
    txn1(1'b1, 32'h10, 4'b1100, 32'h1234_0000, rd, er, lat);
    txn1(1'b0, 32'h10, 4'b0110, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1234AAEF) begin
      errors++; $display("FAIL half1_store got err=%b rdata=%h want 0/1234aaef", er, rd);
    end
    txn1(1'b1, 32'hFFC, 4'b0001, 32'h0000_0077, rd, er, lat);
    txn1(1'b1, 32'hFFC, 4'b1000, 32'h6600_0000, rd, er, lat);
    txn1(1'b1, 32'hFFC, 4'b0100, 32'h0055_0000, rd, er, lat);
    txn1(1'b1, 32'hFFC, 4'b0010, 32'h0000_4400, rd, er, lat);
    txn1(1'b0, 32'hFFC, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h66554477) begin
      errors++; $display("FAIL last_word_bytes got err=%b rdata=%h want 0/66554477", er, rd);
    end
  endtask

  task automatic test_faults();
    logic [31:0] rd; logic er; int lat;
    txn1(1'b0, 32'h1000, 4'b1111, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0 || lat != 2) begin
      errors++; $display("FAIL load_out_of_range got err=%b rdata=%h lat=%0d want 1/0/2", er, rd, lat);
    end
    txn1(1'b0, 32'hFFFF_FFFC, 4'b1111, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL load_wrap_below_base got err=%b rdata=%h want 1/0", er, rd);
    end
    txn1(1'b1, 32'h12, 4'b0011, 32'hFFFF_FFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL store_misaligned got err=%b rdata=%h want 1/0", er, rd);
    end
    txn1(1'b1, 32'h10, 4'b0110, 32'hFFFF_FFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL store_bad_be got err=%b rdata=%h want 1/0", er, rd);
    end
    txn1(1'b1, 32'h1010, 4'b1111, 32'hFFFF_FFFF, rd, er, lat);
    checks++;
    if (er !== 1'b1) begin
      errors++; $display("FAIL store_out_of_range got err=%b want 1", er);
    end
    txn1(1'b0, 32'h10, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h1234AAEF) begin
      errors++; $display("FAIL faulted_stores_no_write got err=%b rdata=%h want 0/1234aaef", er, rd);
    end
    txn1(1'b0, 32'h11, 4'b1111, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b1 || rd !== 32'h0) begin
      errors++; $display("FAIL load_misaligned got err=%b rdata=%h want 1/0", er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; int n; int acc_base;
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = 1'b0; b1.req_addr = 32'h10; b1.req_be = 4'b1111;
    b1.rsp_ready = 1'b0;
    @(negedge clk);
    b1.req_valid = 1'b0;
    n = 0;
    while (!b1.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b1.rsp_valid !== 1'b1) begin
      errors++; $display("FAIL stall_rsp_timeout got rsp_valid=%b want 1", b1.rsp_valid);
    end
    acc_base = acc1_n;
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h14; b1.req_be = 4'b1111;
    b1.req_wdata = 32'h5555_5555;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (b1.rsp_valid !== 1'b1 || b1.rsp_rdata !== 32'h1234AAEF || b1.rsp_err !== 1'b0 ||
          b1.req_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%b d=%h e=%b rdy=%b want 1/1234aaef/0/0", i,
                 b1.rsp_valid, b1.rsp_rdata, b1.rsp_err, b1.req_ready);
      end
      @(negedge clk);
    end
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.rsp_valid !== 1'b0 || b1.req_ready !== 1'b1 || acc1_n != acc_base) begin
      errors++; $display("FAIL stall_release got v=%b rdy=%b accepts=%0d want 0/1/%0d",
                         b1.rsp_valid, b1.req_ready, acc1_n, acc_base);
    end
    @(negedge clk);
    b1.req_valid = 1'b0;
    checks++;
    if (acc1_n != acc_base + 1) begin
      errors++; $display("FAIL stall_then_accept got accepts=%0d want %0d", acc1_n, acc_base + 1);
    end
    n = 0;
    while (!b1.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b1.rsp_valid !== 1'b1 || b1.rsp_err !== 1'b0 || b1.rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL stall_store_rsp got v=%b e=%b d=%h want 1/0/0",
                         b1.rsp_valid, b1.rsp_err, b1.rsp_rdata);
    end
    txn1(1'b0, 32'h14, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h5555_5555) begin
      errors++; $display("FAIL stall_store_readback got err=%b rdata=%h want 0/55555555", er, rd);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int lat;
    txn1(1'b1, 32'h20, 4'b1111, 32'h0, rd, er, lat);
    @(negedge clk);
    b1.req_valid = 1'b1; b1.req_we = 1'b1; b1.req_addr = 32'h20; b1.req_be = 4'b1111;
    b1.req_wdata = 32'hFFFF_FFFF; b1.rsp_ready = 1'b1;
    @(negedge clk);
    b1.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (b1.rsp_valid !== 1'b0 || b1.req_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_in_reset got v=%b rdy=%b want 0/0", b1.rsp_valid, b1.req_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (b1.rsp_valid !== 1'b0 || b1.req_ready !== 1'b1) begin
      errors++; $display("FAIL midreset_release got v=%b rdy=%b want 0/1", b1.rsp_valid, b1.req_ready);
    end
    txn1(1'b0, 32'h20, 4'b0000, 32'h0, rd, er, lat);
    checks++;
    if (er !== 1'b0 || rd !== 32'h0 || lat != 2) begin
      errors++; $display("FAIL midreset_no_write got err=%b rdata=%h lat=%0d want 0/0/2", er, rd, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic        we_v [4];
    logic [31:0] ad_v [4];
    logic [31:0] wd_v [4];
    logic [31:0] exp_d [4];
    int k;
    we_v[0] = 1'b1; ad_v[0] = 32'h40; wd_v[0] = 32'hA5A5_0001; exp_d[0] = 32'h0;
    we_v[1] = 1'b1; ad_v[1] = 32'h44; wd_v[1] = 32'h0BAD_F00D; exp_d[1] = 32'h0;
    we_v[2] = 1'b0; ad_v[2] = 32'h40; wd_v[2] = 32'h0;         exp_d[2] = 32'hA5A5_0001;
    we_v[3] = 1'b0; ad_v[3] = 32'h44; wd_v[3] = 32'h0;         exp_d[3] = 32'h0BAD_F00D;
    @(negedge clk);
    k = 0;
    b0.rsp_ready = 1'b1;
    b0.req_be    = 4'b1111;
    b0.req_we    = we_v[0];
    b0.req_addr  = ad_v[0];
    b0.req_wdata = wd_v[0];
    b0.req_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (acc0_q.size() >= 4) break;
      if (acc0_q.size() > k) begin
        k = acc0_q.size();
        b0.req_we    = we_v[k];
        b0.req_addr  = ad_v[k];
        b0.req_wdata = wd_v[k];
      end
    end
    b0.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (acc0_q.size() != 4 || rsp0_c.size() != 4) begin
      errors++; $display("FAIL b2b_counts got accepts=%0d rsps=%0d want 4/4",
                         acc0_q.size(), rsp0_c.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (i > 0) begin
          checks++;
          if (acc0_q[i] - acc0_q[i-1] != 2) begin
            errors++; $display("FAIL b2b_spacing[%0d] got %0d want 2", i, acc0_q[i] - acc0_q[i-1]);
          end
        end
        checks++;
        if (rsp0_c[i] - acc0_q[i] != 1) begin
          errors++; $display("FAIL b2b_latency[%0d] got %0d want 1", i, rsp0_c[i] - acc0_q[i]);
        end
        checks++;
        if (rsp0_d[i] !== exp_d[i] || rsp0_e[i] !== 1'b0) begin
          errors++; $display("FAIL b2b_data[%0d] got d=%h e=%b want %h/0", i, rsp0_d[i],
                             rsp0_e[i], exp_d[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_byte_enable();
    test_faults();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
